regfile_wr_arbiter: RTL and testbench

- Write-port scheduler for the 32-entry x 64-bit dual-write-port register file.
- After reset, sequences a zero-initialisation of all entries using both write ports.
- Then shares the two write ports (A, B) among NREQ requesters with round-robin fairness.
- Never issues two writes to the same address in one cycle, so the register file's port-A/port-B same-address collision cannot occur.

---
 rtl/regfile_wr_arbiter_if.sv | 29 ++
 rtl/regfile_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Request bus plus the two registered write ports of the register file.
// master = requester side, slave = the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 64
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               a_we;
  logic [AW-1:0]      a_addr;
  logic [DW-1:0]      a_data;
  logic               b_we;
  logic [AW-1:0]      b_addr;
  logic [DW-1:0]      b_data;
  logic               init_done;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, a_we, a_addr, a_data, b_we, b_addr, b_data, init_done
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, a_we, a_addr, a_data, b_we, b_addr, b_data, init_done
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Dual write-port scheduler: zero-fills the register file after reset, then grants up to
// two round-robin requesters per cycle with distinct addresses onto ports A and B.
module regfile_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int KW = AW - 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t        state_reg;
  logic [KW-1:0] init_cnt_reg;
  logic [PW-1:0] rr_ptr_reg;
  logic          a_we_reg;
  logic [AW-1:0] a_addr_reg;
  logic [DW-1:0] a_data_reg;
  logic          b_we_reg;
  logic [AW-1:0] b_addr_reg;
  logic [DW-1:0] b_data_reg;
  logic          init_done_reg;

  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = bus.req_addr[gi*AW +: AW];
      assign data_arr[gi] = bus.req_data[gi*DW +: DW];
    end
  endgenerate

  logic            a_found;
  logic            b_found;
  logic [PW-1:0]   a_idx;
  logic [PW-1:0]   b_idx;
  logic [PW-1:0]   scan_idx;
  logic [PW:0]     scan_sum;
  logic [PW-1:0]   last_idx;
  logic [PW-1:0]   rr_ptr_next;
  logic [NREQ-1:0] grant_mask;

  // Scan from rr_ptr; B is the next valid requester whose address differs from A's.
  always_comb begin
    a_found    = 1'b0;
    b_found    = 1'b0;
    a_idx      = '0;
    b_idx      = '0;
    scan_idx   = '0;
    scan_sum   = '0;
    grant_mask = '0;
    for (int off = 0; off < NREQ; off++) begin
      scan_sum = {1'b0, rr_ptr_reg} + (PW+1)'(off);
      if (scan_sum >= (PW+1)'(NREQ)) begin
        scan_sum = scan_sum - (PW+1)'(NREQ);
      end
      scan_idx = scan_sum[PW-1:0];
      if (bus.req_valid[scan_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = scan_idx;
        end else if (!b_found && (addr_arr[scan_idx] != addr_arr[a_idx])) begin
          b_found = 1'b1;
          b_idx   = scan_idx;
        end
      end
    end
    if (a_found) grant_mask[a_idx] = 1'b1;
    if (b_found) grant_mask[b_idx] = 1'b1;
  end

  // Explicit wrap keeps non-power-of-two NREQ from walking into unused indices.
  assign last_idx    = b_found ? b_idx : a_idx;
  assign rr_ptr_next = (last_idx == PW'(NREQ-1)) ? '0 : last_idx + PW'(1);

  assign bus.req_ready = (state_reg == RUN && !rst) ? grant_mask : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= INIT;
      init_cnt_reg  <= '0;
      rr_ptr_reg    <= '0;
      a_we_reg      <= 1'b0;
      a_addr_reg    <= '0;
      a_data_reg    <= '0;
      b_we_reg      <= 1'b0;
      b_addr_reg    <= '0;
      b_data_reg    <= '0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          a_we_reg     <= 1'b1;
          a_addr_reg   <= {init_cnt_reg, 1'b0};
          a_data_reg   <= '0;
          b_we_reg     <= 1'b1;
          b_addr_reg   <= {init_cnt_reg, 1'b1};
          b_data_reg   <= '0;
          init_cnt_reg <= init_cnt_reg + KW'(1);
          if (init_cnt_reg == '1) begin
            state_reg     <= RUN;
            init_done_reg <= 1'b1;
          end
        end
        RUN: begin
          // An idle port drops we but keeps its last address/data.
          a_we_reg <= a_found;
          b_we_reg <= b_found;
          if (a_found) begin
            a_addr_reg <= addr_arr[a_idx];
            a_data_reg <= data_arr[a_idx];
            rr_ptr_reg <= rr_ptr_next;
          end
          if (b_found) begin
            b_addr_reg <= addr_arr[b_idx];
            b_data_reg <= data_arr[b_idx];
          end
        end
        default: state_reg <= INIT;
      endcase
    end
  end

  assign bus.a_we      = a_we_reg;
  assign bus.a_addr    = a_addr_reg;
  assign bus.a_data    = a_data_reg;
  assign bus.b_we      = b_we_reg;
  assign bus.b_addr    = b_addr_reg;
  assign bus.b_data    = b_data_reg;
  assign bus.init_done = init_done_reg;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: a queue-based reference model predicts grants
// and port writes; a negedge monitor pops expectations and compares against the DUT.
module tb_regfile_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int AW    = 5;
  localparam int DW    = 64;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            due;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          init_done;
  } wr_t;

  typedef struct {
    int            due;
    logic [NREQ-1:0] ready;
  } rdy_t;

  wr_t  wr_q[$];
  rdy_t rdy_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester-side pending requests.
  logic [NREQ-1:0] rq_valid;
  logic [AW-1:0]   rq_addr [NREQ];
  logic [DW-1:0]   rq_data [NREQ];

  // Reference model state.
  bit            m_running;
  int            m_k;
  int            m_rr;
  logic [AW-1:0] m_a_addr, m_b_addr;
  logic [DW-1:0] m_a_data, m_b_data;
  logic [DW-1:0] m_mem [DEPTH];

  // Register file image built from what the DUT actually wrote.
  logic [DW-1:0] rf [DEPTH];

  bit fair_en = 1'b0;
  int wait_cnt [NREQ];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One stimulus cycle: apply inputs, predict from the rules, push expectations, retire grants.
  task automatic drive_cycle(input bit r);
    wr_t  w;
    rdy_t q;
    int   order[$];
    int   pend[$];
    int   cand[$];
    int   ga, gb;
    rst = r;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]              = rq_valid[i];
      bus.req_addr[i*AW +: AW]      = rq_addr[i];
      bus.req_data[i*DW +: DW]      = rq_data[i];
    end
    q.due   = cyc;
    q.ready = '0;
    w.due   = cyc + 1;
    ga = -1;
    gb = -1;
    if (r) begin
      m_running = 1'b0;
      m_k = 0;
      m_rr = 0;
      m_a_addr = '0; m_a_data = '0; m_b_addr = '0; m_b_data = '0;
      w.a_we = 1'b0; w.b_we = 1'b0;
    end else if (!m_running) begin
      m_a_addr = AW'(2*m_k);
      m_b_addr = AW'(2*m_k + 1);
      m_a_data = '0;
      m_b_data = '0;
      m_mem[2*m_k]     = '0;
      m_mem[2*m_k + 1] = '0;
      w.a_we = 1'b1; w.b_we = 1'b1;
      m_k++;
      if (m_k == DEPTH/2) m_running = 1'b1;
    end else begin
      for (int n = 0; n < NREQ; n++) order.push_back((m_rr + n) % NREQ);
      pend = order.find(x) with (rq_valid[x] == 1'b1);
      if (pend.size() > 0) begin
        ga = pend[0];
        cand = pend.find_first(x) with (rq_addr[x] != rq_addr[ga]);
        if (cand.size() > 0) gb = cand[0];
      end
      w.a_we = (ga >= 0);
      w.b_we = (gb >= 0);
      if (ga >= 0) begin
        q.ready[ga] = 1'b1;
        m_a_addr = rq_addr[ga];
        m_a_data = rq_data[ga];
        m_mem[rq_addr[ga]] = rq_data[ga];
        m_rr = (((gb >= 0) ? gb : ga) + 1) % NREQ;
      end
      if (gb >= 0) begin
        q.ready[gb] = 1'b1;
        m_b_addr = rq_addr[gb];
        m_b_data = rq_data[gb];
        m_mem[rq_addr[gb]] = rq_data[gb];
      end
    end
    w.a_addr = m_a_addr; w.a_data = m_a_data;
    w.b_addr = m_b_addr; w.b_data = m_b_data;
    w.init_done = m_running;
    rdy_q.push_back(q);
    wr_q.push_back(w);
    if (ga >= 0) rq_valid[ga] = 1'b0;
    if (gb >= 0) rq_valid[gb] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input int i, input int addr, input logic [DW-1:0] data);
    if (!rq_valid[i]) begin
      rq_valid[i] = 1'b1;
      rq_addr[i]  = AW'(addr);
      rq_data[i]  = data;
    end
  endtask

  always @(negedge clk) begin : monitor
    rdy_t re;
    wr_t  we;
    if (rdy_q.size() > 0 && rdy_q[0].due == cyc) begin
      re = rdy_q.pop_front();
      chk("req_ready", 64'(bus.req_ready), 64'(re.ready));
    end
    if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
      we = wr_q.pop_front();
      chk("a_we", 64'(bus.a_we), 64'(we.a_we));
      chk("b_we", 64'(bus.b_we), 64'(we.b_we));
      chk("a_addr", 64'(bus.a_addr), 64'(we.a_addr));
      chk("a_data", bus.a_data, we.a_data);
      chk("b_addr", 64'(bus.b_addr), 64'(we.b_addr));
      chk("b_data", bus.b_data, we.b_data);
      chk("init_done", 64'(bus.init_done), 64'(we.init_done));
      if (bus.a_we || bus.b_we) begin
        $display("[TB] cyc %0d A(we=%0b addr=%0d data=%h) B(we=%0b addr=%0d data=%h)",
                 cyc, bus.a_we, bus.a_addr, bus.a_data, bus.b_we, bus.b_addr, bus.b_data);
      end
    end
    if (bus.a_we && bus.b_we) chk("ab_same_addr", 64'(bus.a_addr == bus.b_addr), 64'd0);
    if (bus.a_we === 1'b1) rf[bus.a_addr] = bus.a_data;
    if (bus.b_we === 1'b1) rf[bus.b_addr] = bus.b_data;
    for (int i = 0; i < NREQ; i++) begin
      if (fair_en && bus.req_valid[i]) begin
        if (bus.req_ready[i]) wait_cnt[i] = 0;
        else begin
          wait_cnt[i]++;
          chk($sformatf("fair_wait_req%0d", i), 64'(wait_cnt[i] >= NREQ), 64'd0);
        end
      end else begin
        wait_cnt[i] = 0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rq_addr[i]  = '0;
      rq_data[i]  = '0;
      wait_cnt[i] = 0;
    end
    rq_valid = '0;
    @(posedge clk);
    #1;

    // Reset then full zero-fill with every requester asserting valid.
    for (int i = 0; i < NREQ; i++) arm(i, 10 + i, 64'(100 + i));
    drive_cycle(1'b1);
    drive_cycle(1'b1);
    repeat (DEPTH/2) drive_cycle(1'b0);
    rq_valid = '0;
    drive_cycle(1'b0);

    // Single write from requester 2 (rr_ptr is 0 here).
    arm(2, 5, 64'hDEAD);
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    chk("read_addr5", rf[5], 64'hDEAD);

    // Return rr_ptr to 0, then the full-load case.
    arm(3, 9, 64'h9);
    drive_cycle(1'b0);
    for (int i = 0; i < NREQ; i++) arm(i, i + 1, 64'(16'hA0 + i));
    drive_cycle(1'b0);
    drive_cycle(1'b0);

    // Same-address conflict: serialised, requester 1 writes last.
    arm(0, 7, 64'd1);
    arm(1, 7, 64'd2);
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    chk("read_addr7", rf[7], 64'd2);

    // Fairness with continuously valid requesters.
    fair_en = 1'b1;
    repeat (6) begin
      arm(0, 20, {$urandom, $urandom});
      arm(3, 21, {$urandom, $urandom});
      drive_cycle(1'b0);
    end
    repeat (8) begin
      for (int i = 0; i < NREQ; i++) arm(i, 20 + i, {$urandom, $urandom});
      drive_cycle(1'b0);
    end
    fair_en = 1'b0;
    rq_valid = '0;

    // Reset in the middle of initialisation restarts it from the beginning.
    drive_cycle(1'b1);
    repeat (8) drive_cycle(1'b0);
    for (int i = 0; i < NREQ; i++) arm(i, 12 + i, 64'(200 + i));
    drive_cycle(1'b1);
    repeat (DEPTH/2) drive_cycle(1'b0);

    // Randomised traffic with conflicts, drops and one reset.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rq_valid[i]) begin
          if ($urandom_range(0, 99) < 70)
            arm(i, ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH-1)),
                {$urandom, $urandom});
        end else if ($urandom_range(0, 99) < 5) begin
          rq_valid[i] = 1'b0;
        end
      end
      drive_cycle(c == 150);
    end

    rq_valid = '0;
    repeat (3) drive_cycle(1'b0);
    repeat (2) @(negedge clk);
    #1;
    for (int a = 0; a < DEPTH; a++) chk($sformatf("regfile[%0d]", a), rf[a], m_mem[a]);
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk("rdy_q_drained", 64'(rdy_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
